// File: rtl/signal_history_pkg.sv
// Shared definitions for the signal_history block.
//   clog2     : ceiling log2, used to size tap select and fill count ports
//   MODE_*    : capture mode encodings for the mode input
//   slice_lo  : low bit index of element idx in a flattened bus of width-bit elements
package signal_history_pkg;

    localparam logic MODE_EVERY  = 1'b0;
    localparam logic MODE_CHANGE = 1'b1;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < value) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
        return idx * width;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset : clock, asynchronous active-high reset
//   inc        : count up by one unless already at MAX
//   clr        : synchronous clear, wins over inc
//   count      : current count
module sat_counter #(
    parameter int unsigned W   = 8,
    parameter logic [W-1:0] MAX = {W{1'b1}}
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/signal_history.sv
// Multi-stage history register for one WIDTH-bit signal.
//   clk, reset : clock, asynchronous active-high reset
//   din        : tracked signal
//   en, flush  : sample enable, synchronous clear (flush wins)
//   mode       : MODE_EVERY captures every enabled cycle, MODE_CHANGE only when din != p1
//   tap_sel    : selects stage p(tap_sel+1) onto tap_out, tap_valid flags real data
//   hist       : all stages flattened, p1 in the low WIDTH bits
//   fill       : number of valid stages, saturating at DEPTH
//   rise, fall : per-bit edges of din against p1, zero while history is empty
//   stable_cnt : consecutive enabled samples with din == p1, saturating
module signal_history
    import signal_history_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned STABLE_W = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              din,
    input  logic                          en,
    input  logic                          flush,
    input  logic                          mode,
    input  logic [clog2(DEPTH)-1:0]       tap_sel,
    output logic [DEPTH*WIDTH-1:0]        hist,
    output logic [WIDTH-1:0]              tap_out,
    output logic                          tap_valid,
    output logic [clog2(DEPTH+1)-1:0]     fill,
    output logic [WIDTH-1:0]              rise,
    output logic [WIDTH-1:0]              fall,
    output logic [STABLE_W-1:0]           stable_cnt
);

    localparam int unsigned FILL_W = clog2(DEPTH + 1);

    logic [DEPTH*WIDTH-1:0] hist_q;
    logic [DEPTH*WIDTH-1:0] hist_d;
    logic [WIDTH-1:0]       p1;
    logic                   empty;
    logic                   same;
    logic                   cap;
    logic                   stable_inc;
    logic                   stable_clr;

    assign p1    = hist_q[WIDTH-1:0];
    assign empty = (fill == '0);
    assign same  = (din == p1);

    // In change mode the first sample is always taken so p1 holds real data.
    assign cap = en && !flush && ((mode == MODE_CHANGE) ? (empty || !same) : 1'b1);

    always_comb begin
        hist_d = hist_q;
        if (flush) begin
            hist_d = '0;
        end else if (cap) begin
            hist_d = {hist_q[(DEPTH-1)*WIDTH-1:0], din};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    sat_counter #(
        .W   (FILL_W),
        .MAX (FILL_W'(DEPTH))
    ) u_fill (
        .clk   (clk),
        .reset (reset),
        .inc   (cap),
        .clr   (flush),
        .count (fill)
    );

    // Stability tracks enabled samples independent of capture, so it keeps
    // counting in change mode while the history itself is frozen.
    assign stable_inc = en && !flush && !empty && same;
    assign stable_clr = flush || (en && (empty || !same));

    sat_counter #(
        .W (STABLE_W)
    ) u_stable (
        .clk   (clk),
        .reset (reset),
        .inc   (stable_inc),
        .clr   (stable_clr),
        .count (stable_cnt)
    );

    // Out-of-range selects (non-power-of-two DEPTH) match no stage and leave zeros.
    always_comb begin
        tap_out = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            if (32'(tap_sel) == k) begin
                tap_out = hist_q[slice_lo(k, WIDTH) +: WIDTH];
            end
        end
    end

    // fill never exceeds DEPTH, so an out-of-range select is never valid.
    assign tap_valid = (32'(tap_sel) < 32'(fill));

    assign rise = empty ? '0 : (din & ~p1);
    assign fall = empty ? '0 : (~din & p1);
    assign hist = hist_q;

endmodule

// File: tb/tb_signal_history.sv
module tb_signal_history;

    typedef enum int {
        SHist, STap, STapV, SFill, SRise, SFall, SStab,
        SHist2, STap2, STapV2, SFill2, SStab2
    } sel_e;

    typedef struct {
        string       name;
        sel_e        sel;
        logic [31:0] exp;
    } chk_t;

    chk_t chk_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    logic clk = 1'b0;
    logic reset;

    // DUT 1: WIDTH=8, DEPTH=4, STABLE_W=8
    logic [7:0]  din;
    logic        en, flush, mode;
    logic [1:0]  tap_sel;
    logic [31:0] hist;
    logic [7:0]  tap_out, rise, fall, stable_cnt;
    logic        tap_valid;
    logic [2:0]  fill;

    // DUT 2: WIDTH=8, DEPTH=3 (non-power-of-two), STABLE_W=2
    logic [7:0]  din2;
    logic        en2, flush2, mode2;
    logic [1:0]  tap_sel2;
    logic [23:0] hist2;
    logic [7:0]  tap_out2, rise2, fall2;
    logic        tap_valid2;
    logic [1:0]  fill2;
    logic [1:0]  stable_cnt2;

    always #5 clk = ~clk;

    signal_history #(.WIDTH(8), .DEPTH(4), .STABLE_W(8)) u_dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .en         (en),
        .flush      (flush),
        .mode       (mode),
        .tap_sel    (tap_sel),
        .hist       (hist),
        .tap_out    (tap_out),
        .tap_valid  (tap_valid),
        .fill       (fill),
        .rise       (rise),
        .fall       (fall),
        .stable_cnt (stable_cnt)
    );

    signal_history #(.WIDTH(8), .DEPTH(3), .STABLE_W(2)) u_dut2 (
        .clk        (clk),
        .reset      (reset),
        .din        (din2),
        .en         (en2),
        .flush      (flush2),
        .mode       (mode2),
        .tap_sel    (tap_sel2),
        .hist       (hist2),
        .tap_out    (tap_out2),
        .tap_valid  (tap_valid2),
        .fill       (fill2),
        .rise       (rise2),
        .fall       (fall2),
        .stable_cnt (stable_cnt2)
    );

    function automatic logic [31:0] actual(input sel_e sel);
        case (sel)
            SHist:   return hist;
            STap:    return 32'(tap_out);
            STapV:   return 32'(tap_valid);
            SFill:   return 32'(fill);
            SRise:   return 32'(rise);
            SFall:   return 32'(fall);
            SStab:   return 32'(stable_cnt);
            SHist2:  return 32'(hist2);
            STap2:   return 32'(tap_out2);
            STapV2:  return 32'(tap_valid2);
            SFill2:  return 32'(fill2);
            SStab2:  return 32'(stable_cnt2);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: consumes pending expectations at the falling edge.
    initial begin
        chk_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0) begin
                e   = chk_q.pop_front();
                act = actual(e.sel);
                n_checks++;
                if (act !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %0h expected %0h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic push(input string name, input sel_e sel, input logic [31:0] v);
        chk_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = v;
        chk_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m1_din [5];
        logic [7:0] m1_stab[5];
        logic [2:0] m1_fill[5];
        logic [1:0] s2_exp [6];
        m1_din  = '{8'd7, 8'd7, 8'd7, 8'd9, 8'd9};
        m1_stab = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1};
        m1_fill = '{3'd1, 3'd1, 3'd1, 3'd2, 3'd2};
        s2_exp  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

        reset = 1'b1;
        din = 8'hFF; en = 1'b0; flush = 1'b0; mode = 1'b0; tap_sel = 2'd0;
        din2 = 8'h00; en2 = 1'b0; flush2 = 1'b0; mode2 = 1'b0; tap_sel2 = 2'd0;

        // Reset state
        tick();
        push("rst_hist", SHist, 32'h0);
        push("rst_fill", SFill, 32'd0);
        push("rst_stab", SStab, 32'd0);
        push("rst_tapv", STapV, 32'd0);
        push("rst_rise", SRise, 32'h0);
        push("rst_fall", SFall, 32'h0);
        push("rst_fill2", SFill2, 32'd0);
        settle();
        reset = 1'b0;

        // Single capture, tap beyond fill is invalid
        din = 8'hA5; en = 1'b1; tap_sel = 2'd2;
        tick();
        en = 1'b0;
        push("one_hist", SHist, 32'h0000_00A5);
        push("one_fill", SFill, 32'd1);
        push("one_tapv", STapV, 32'd0);
        settle();

        reset = 1'b1;
        tick();
        push("rst2_fill", SFill, 32'd0);
        settle();
        reset = 1'b0;

        // Mode 0 fill sequence 1..5
        for (int i = 1; i <= 5; i++) begin
            din = 8'(i); en = 1'b1;
            tick();
            push("seq_fill", SFill, (i < 4) ? 32'(i) : 32'd4);
            settle();
        end
        en = 1'b0; tap_sel = 2'd3;
        push("seq_hist", SHist, 32'h0203_0405);
        push("seq_tap", STap, 32'h02);
        push("seq_tapv", STapV, 32'd1);
        push("seq_stab", SStab, 32'd0);
        settle();

        // Hold with en=0
        din = 8'h77;
        tick();
        push("hold_hist", SHist, 32'h0203_0405);
        push("hold_fill", SFill, 32'd4);
        settle();

        // Rise/fall against p1=F0
        din = 8'hF0; en = 1'b1;
        tick();
        en = 1'b0; din = 8'h0F;
        push("rf_hist", SHist, 32'h0304_05F0);
        push("rf_rise", SRise, 32'h0F);
        push("rf_fall", SFall, 32'hF0);
        settle();

        // Flush overrides en
        din = 8'h33; en = 1'b1; flush = 1'b1; tap_sel = 2'd0;
        tick();
        flush = 1'b0; en = 1'b0;
        push("fl_hist", SHist, 32'h0);
        push("fl_fill", SFill, 32'd0);
        push("fl_stab", SStab, 32'd0);
        push("fl_tapv", STapV, 32'd0);
        push("fl_rise", SRise, 32'h0);
        settle();

        // Mode 1: 7,7,7,9,9
        mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            din = m1_din[i]; en = 1'b1;
            tick();
            push("m1_stab", SStab, 32'(m1_stab[i]));
            push("m1_fill", SFill, 32'(m1_fill[i]));
            settle();
        end
        en = 1'b0;
        push("m1_hist", SHist, 32'h0000_0709);
        settle();

        // Asynchronous reset between edges
        tick();
        #2;
        reset = 1'b1;
        #1;
        push("ar_hist", SHist, 32'h0);
        push("ar_fill", SFill, 32'd0);
        push("ar_stab", SStab, 32'd0);
        push("ar_tapv", STapV, 32'd0);
        push("ar_rise", SRise, 32'h0);
        settle();
        reset = 1'b0;

        // DUT2: stability saturation at 3, then change
        din2 = 8'd3; en2 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            push("s2_stab", SStab2, 32'(s2_exp[i]));
            settle();
        end
        din2 = 8'd4;
        tick();
        en2 = 1'b0;
        push("s2_chg", SStab2, 32'd0);
        push("s2_fill", SFill2, 32'd3);
        push("s2_hist", SHist2, 32'h0003_0304);
        tap_sel2 = 2'd3;
        push("s2_oor_tap", STap2, 32'h0);
        push("s2_oor_tapv", STapV2, 32'd0);
        settle();
        tap_sel2 = 2'd2;
        push("s2_tap", STap2, 32'h03);
        push("s2_tapv", STapV2, 32'd1);
        settle();

        for (int i = 0; i < 10 && chk_q.size() != 0; i++) @(negedge clk);
        #1;
        if (chk_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", chk_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
